// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 access-type
// constants and the split-access FSM state type.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_e;

endpackage

// File: rtl/dmem_align.sv
// Purely combinational lane logic: byte enables and store-data placement over
// a two-word window, plus load extraction and sign/zero extension.
module dmem_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] lo_word_i,
    input  logic [31:0] hi_word_i,
    output logic [7:0]  be_o,
    output logic [63:0] wdat_o,
    output logic [31:0] rdata_o
);

    logic [3:0]  size_mask;
    logic [31:0] span;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        size_mask = 4'b0000;
        case (funct3_i)
            F3_B, F3_BU: size_mask = 4'b0001;
            F3_H, F3_HU: size_mask = 4'b0011;
            F3_W:        size_mask = 4'b1111;
            default:     size_mask = 4'b0000;
        endcase
    end

    // Bits [7:4] / [63:32] are the lanes that spill into the next word.
    assign be_o   = {4'b0000, size_mask} << offset_i;
    assign wdat_o = {32'h0, wdata_i} << {offset_i, 3'b000};
    assign span   = 32'({hi_word_i, lo_word_i} >> {offset_i, 3'b000});

    always_comb begin
        rdata_o = 32'h0;
        case (funct3_i)
            F3_B:    rdata_o = {{24{span[7]}}, span[7:0]};
            F3_BU:   rdata_o = {24'h0, span[7:0]};
            F3_H:    rdata_o = {{16{span[15]}}, span[15:0]};
            F3_HU:   rdata_o = {16'h0, span[15:0]};
            F3_W:    rdata_o = span;
            default: rdata_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_resp.sv
// Word-organised data memory with sticky access-fault capture. Define
// DMEM_MISALIGN_EN to split word-crossing accesses over two cycles.
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic        re,
    input  logic [2:0]  memcontrol,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        fault,
    output logic [31:0] fault_addr
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];

    logic          in_split;
    logic          eff_we, eff_re;
    logic [2:0]    eff_f3;
    logic [31:0]   eff_addr, eff_wdata;
    logic [23:0]   hold;

    logic [AW-1:0] idx, acc_idx;
    logic [7:0]    be;
    logic [63:0]   wdat;
    logic [31:0]   rd_word, lo_word, hi_word, ld_data;
    logic          access, crosses, illegal_f3, out_of_range, bad_store;
    logic          cross_fault, fault_now, wr_en;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;
    logic          fault_q;
    logic [31:0]   fault_addr_q;

    assign idx     = eff_addr[AW+1:2];
    assign acc_idx = in_split ? idx + AW'(1) : idx;
    assign rd_word = mem[acc_idx];
    assign lo_word = in_split ? {hold, 8'h00} : rd_word;
    assign hi_word = in_split ? rd_word : 32'h0;

    dmem_align u_align (
        .funct3_i  (eff_f3),
        .offset_i  (eff_addr[1:0]),
        .wdata_i   (eff_wdata),
        .lo_word_i (lo_word),
        .hi_word_i (hi_word),
        .be_o      (be),
        .wdat_o    (wdat),
        .rdata_o   (ld_data)
    );

    assign access       = eff_we | eff_re;
    assign crosses      = |be[7:4];
    assign illegal_f3   = !(eff_f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    assign out_of_range = |eff_addr[31:AW+2];
    assign bad_store    = eff_we & ((eff_f3 == F3_BU) | (eff_f3 == F3_HU));

    // The second cycle of a split was validated in the first, so it never faults.
    assign fault_now = !in_split & access &
                       ((eff_we & eff_re) | illegal_f3 | out_of_range | bad_store | cross_fault);

    assign rdata   = (eff_re & !fault_now & (in_split | !crosses)) ? ld_data : 32'h0;
    assign wr_en   = reset & eff_we & !fault_now;
    assign wr_be   = in_split ? be[7:4]    : be[3:0];
    assign wr_data = in_split ? wdat[63:32] : wdat[31:0];

`ifdef DMEM_MISALIGN_EN
    state_e      state_q, state_d;
    logic [23:0] hold_q, hold_d;
    logic        we_q, re_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q;
    logic        start_split;

    // Only a crossing access at the very last word straddles the top of memory.
    assign cross_fault = crosses & (&idx);
    assign in_split    = (state_q == SPLIT);
    assign eff_we      = in_split ? we_q    : we;
    assign eff_re      = in_split ? re_q    : re;
    assign eff_f3      = in_split ? f3_q    : memcontrol;
    assign eff_addr    = in_split ? addr_q  : addr;
    assign eff_wdata   = in_split ? wdata_q : wdata;
    assign hold        = hold_q;
    assign start_split = reset & !in_split & access & crosses & !fault_now;
    assign stall       = start_split;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (start_split) begin
                    state_d = SPLIT;
                    if (eff_re) hold_d = rd_word[31:8];
                end
            end
            SPLIT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            if (start_split) begin
                we_q    <= we;
                re_q    <= re;
                f3_q    <= memcontrol;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
        end
    end
`else
    assign cross_fault = crosses;
    assign in_split    = 1'b0;
    assign eff_we      = we;
    assign eff_re      = re;
    assign eff_f3      = memcontrol;
    assign eff_addr    = addr;
    assign eff_wdata   = wdata;
    assign hold        = '0;
    assign stall       = 1'b0;
`endif

    // NOTE: storage has no reset branch; contents must survive reset and map to plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[acc_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else if (fault_now) begin
            fault_q <= 1'b1;
            if (!fault_q) fault_addr_q <= eff_addr;
        end
    end

    assign fault      = fault_q;
    assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: byte-array reference model, per-cycle
// compare process, directed scenarios and randomized accesses.
module tb_dmem_resp;

    localparam int          DEPTH  = 64;
    localparam int unsigned NBYTES = DEPTH * 4;
`ifdef DMEM_MISALIGN_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        we = 1'b0, re = 1'b0;
    logic [2:0]  memcontrol = 3'b000;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic [31:0] rdata, fault_addr;
    logic        stall, fault;

    dmem_resp #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .re         (re),
        .memcontrol (memcontrol),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .stall      (stall),
        .fault      (fault),
        .fault_addr (fault_addr)
    );

    always #5 clk = ~clk;

    logic [7:0]  mbytes [NBYTES];
    logic        fault_m = 1'b0;
    logic [31:0] faddr_m = 32'h0;
    logic        chk_en = 1'b0;
    logic [31:0] exp_rdata = 32'h0;
    logic        exp_stall = 1'b0;
    logic [31:0] seen_rdata = 32'h0;
    int          stall_cnt = 0;
    logic        prev_stall = 1'b0;
    int          n_checks = 0, n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < size_of(f3); i++) v[8*i +: 8] = mbytes[int'(a) + i];
        case (f3)
            3'b000:  v = {{24{v[7]}}, v[7:0]};
            3'b001:  v = {{16{v[15]}}, v[15:0]};
            default: v = v;
        endcase
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("rdata", rdata, exp_rdata);
            check("stall", 32'(stall), 32'(exp_stall));
            check("fault", 32'(fault), 32'(fault_m));
            check("fault_addr", fault_addr, faddr_m);
            check("stall_2cyc", 32'(prev_stall & stall), 32'h0);
            seen_rdata = rdata;
            if (stall) stall_cnt++;
        end
        prev_stall = stall;
    end

    // Called just after a rising edge; returns just after the edge that completes the access.
    task automatic access(input logic w, input logic r, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input bit scramble);
        int sz, off;
        longint unsigned end_a;
        bit misal, flt, split;
        logic [31:0] lv;
        sz    = size_of(f3);
        off   = int'(a[1:0]);
        end_a = longint'(a) + longint'(sz);
        misal = (sz != 0) && (off + sz > 4);
        flt   = (w || r) && ((w && r) || sz == 0 || end_a > NBYTES ||
                             (w && (f3 == 3'b100 || f3 == 3'b101)) || (misal && !MIS));
        split = (w || r) && !flt && misal;
        lv    = (r && !flt) ? load_val(f3, a) : 32'h0;
        we = w; re = r; memcontrol = f3; addr = a; wdata = wd;
        exp_rdata = split ? 32'h0 : lv;
        exp_stall = split;
        stall_cnt = 0;
        chk_en    = 1'b1;
        @(posedge clk);
        if (flt) begin
            if (!fault_m) faddr_m = a;
            fault_m = 1'b1;
        end else if (w) begin
            for (int i = 0; i < sz; i++) if (off + i < 4) mbytes[int'(a) + i] = wd[8*i +: 8];
        end
        #1;
        if (split) begin
            if (scramble) begin
                we = 1'($urandom_range(0, 1));
                re = 1'($urandom_range(0, 1));
                memcontrol = 3'($urandom_range(0, 7));
                addr = $urandom;
                wdata = $urandom;
            end
            exp_rdata = lv;
            exp_stall = 1'b0;
            @(posedge clk);
            if (w) for (int i = 0; i < sz; i++) if (off + i >= 4) mbytes[int'(a) + i] = wd[8*i +: 8];
            #1;
        end
    endtask

    // Asserts reset between edges with the previous inputs still applied.
    task automatic pulse_reset();
        chk_en = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        check("rst_fault_addr", fault_addr, 32'h0);
        fault_m = 1'b0;
        faddr_m = 32'h0;
        we = 1'b0;
        re = 1'b0;
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        logic        w, r;
        int          k, sel;

        #3;
        check("init_stall", 32'(stall), 32'h0);
        check("init_fault", 32'(fault), 32'h0);
        check("init_fault_addr", fault_addr, 32'h0);
        check("init_rdata", rdata, 32'h0);
        #4;
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < DEPTH; i++) access(1'b1, 1'b0, 3'b010, 32'(i * 4), $urandom, 1'b0);

        access(1'b1, 1'b0, 3'b010, 32'h10, 32'h8000_00FF, 1'b0);
        access(1'b0, 1'b1, 3'b000, 32'h13, 32'h0, 1'b0);
        check("lb_13", seen_rdata, 32'hFFFF_FF80);
        check("model_lb_13", load_val(3'b000, 32'h13), 32'hFFFF_FF80);
        access(1'b0, 1'b1, 3'b100, 32'h10, 32'h0, 1'b0);
        check("lbu_10", seen_rdata, 32'h0000_00FF);
        access(1'b0, 1'b1, 3'b001, 32'h12, 32'h0, 1'b0);
        check("lh_12", seen_rdata, 32'hFFFF_8000);
        check("model_lh_12", load_val(3'b001, 32'h12), 32'hFFFF_8000);

        access(1'b1, 1'b0, 3'b010, 32'h20, 32'h1122_3344, 1'b0);
        access(1'b1, 1'b0, 3'b000, 32'h21, 32'h0000_00AB, 1'b0);
        access(1'b0, 1'b1, 3'b010, 32'h20, 32'h0, 1'b0);
        check("sb_21_word", seen_rdata, 32'h1122_AB44);
        access(1'b0, 1'b1, 3'b101, 32'h22, 32'h0, 1'b0);
        check("lhu_22", seen_rdata, 32'h0000_1122);

        pulse_reset();
`ifdef DMEM_MISALIGN_EN
        access(1'b1, 1'b0, 3'b010, 32'h42, 32'hDEAD_BEEF, 1'b0);
        check("sw_42_stall_cycles", 32'(stall_cnt), 32'd1);
        access(1'b0, 1'b1, 3'b010, 32'h42, 32'h0, 1'b0);
        check("lw_42_stall_cycles", 32'(stall_cnt), 32'd1);
        check("lw_42_data", seen_rdata, 32'hDEAD_BEEF);
        check("model_lw_42", load_val(3'b010, 32'h42), 32'hDEAD_BEEF);
        access(1'b0, 1'b1, 3'b101, 32'h42, 32'h0, 1'b0);
        check("word40_upper", seen_rdata, 32'h0000_BEEF);
        check("split_fault", 32'(fault), 32'h0);
`else
        access(1'b0, 1'b1, 3'b010, 32'h41, 32'h0, 1'b0);
        check("lw_41_fault", 32'(fault), 32'h1);
        check("lw_41_fault_addr", fault_addr, 32'h41);
        check("lw_41_rdata", seen_rdata, 32'h0);
        check("lw_41_no_stall", 32'(stall_cnt), 32'd0);
`endif

        pulse_reset();
        access(1'b1, 1'b0, 3'b010, 32'h0, 32'h0BAD_F00D, 1'b0);
        access(1'b1, 1'b0, 3'b010, NBYTES, 32'h5A5A_5A5A, 1'b0);
        check("oor_fault", 32'(fault), 32'h1);
        check("oor_fault_addr", fault_addr, 32'h100);
        access(1'b0, 1'b1, 3'b010, 32'h0, 32'h0, 1'b0);
        check("oor_no_write", seen_rdata, 32'h0BAD_F00D);
        access(1'b0, 1'b1, 3'b011, 32'h7, 32'h0, 1'b0);
        check("second_fault_addr", fault_addr, 32'h100);
        check("second_fault_flag", 32'(fault), 32'h1);

        for (int it = 0; it < 1500; it++) begin
            if (it % 300 == 299) pulse_reset();
            k = int'($urandom_range(0, 9));
            w = (k >= 4 && k < 8) || k == 9;
            r = (k < 4) || k == 9;
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) while (size_of(f3) == 0) f3 = 3'($urandom_range(0, 7));
            sel = int'($urandom_range(0, 15));
            if (sel == 0)      a = NBYTES - $urandom_range(0, 4);
            else if (sel == 1) a = $urandom;
            else               a = $urandom_range(0, NBYTES - 1);
            access(w, r, f3, a, $urandom, 1'b1);
        end

`ifdef DMEM_MISALIGN_EN
        pulse_reset();
        access(1'b1, 1'b0, 3'b010, 32'h0, 32'h1111_1111, 1'b0);
        access(1'b1, 1'b0, 3'b010, 32'h4, 32'h2222_2222, 1'b0);
        we = 1'b1; re = 1'b0; memcontrol = 3'b010; addr = 32'h2; wdata = 32'hCAFE_F00D;
        exp_rdata = 32'h0;
        exp_stall = 1'b1;
        stall_cnt = 0;
        chk_en    = 1'b1;
        @(posedge clk);
        mbytes[2] = 8'h0D;
        mbytes[3] = 8'hF0;
        #1;
        check("midsplit_stalled", 32'(stall_cnt), 32'd1);
        pulse_reset();
        access(1'b0, 1'b1, 3'b010, 32'h0, 32'h0, 1'b0);
        check("midsplit_low_word", seen_rdata, 32'hF00D_1111);
        check("midsplit_no_stall", 32'(stall_cnt), 32'd0);
        access(1'b0, 1'b1, 3'b010, 32'h4, 32'h0, 1'b0);
        check("midsplit_high_word", seen_rdata, 32'h2222_2222);
`else
        pulse_reset();
        access(1'b1, 1'b0, 3'b010, 32'h2, 32'hCAFE_F00D, 1'b0);
        check("sw_2_fault", 32'(fault), 32'h1);
        check("sw_2_fault_addr", fault_addr, 32'h2);
`endif

        chk_en = 1'b0;
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
